rr_stream_arbiter: RTL and testbench

RR_STREAM_ARBITER -- requirements
Module: rr_stream_arbiter

---
 rtl/rr_stream_arbiter.sv | 152 +++++++++++++++
 tb/tb_rr_stream_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_arbiter.sv
// Round-robin packet arbiter: N_REQ valid/ready streams merged onto one
// registered output stream. A multi-beat packet holds its grant until last_i,
// so packets from different requesters are never interleaved.
module rr_stream_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        valid_i,
    output logic [N_REQ-1:0]        ready_o,
    input  logic [N_REQ*DATA_W-1:0] data_i,
    input  logic [N_REQ-1:0]        last_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [DATA_W-1:0]       data_o,
    output logic                    last_o,
    output logic [ID_W-1:0]         src_o,
    output logic                    busy_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   owner;
    logic [ID_W-1:0]   rr_ptr;

    logic              load_en;
    logic              hi_found;
    logic [ID_W-1:0]   hi_pick;
    logic              lo_found;
    logic [ID_W-1:0]   lo_pick;
    logic              sel_found;
    logic [ID_W-1:0]   sel;
    logic [DATA_W-1:0] sel_data;
    logic              sel_last;
    logic              xfer;
    logic [ID_W-1:0]   next_ptr;

    // The output register may accept a new beat when it is empty or draining.
    assign load_en = ~valid_o | ready_i;

    // Rotating priority search: lowest valid index at or above rr_ptr wins,
    // otherwise wrap around to the lowest valid index overall.
    always_comb begin
        hi_found = 1'b0;
        hi_pick  = '0;
        lo_found = 1'b0;
        lo_pick  = '0;
        for (int r = N_REQ - 1; r >= 0; r--) begin
            if (valid_i[r]) begin
                lo_found = 1'b1;
                lo_pick  = ID_W'(r);
                if (ID_W'(r) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_pick  = ID_W'(r);
                end
            end
        end
    end

    // A locked packet owner keeps the grant even through valid bubbles.
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        if (state == LOCKED) begin
            sel_found = 1'b1;
            sel       = owner;
        end else if (hi_found) begin
            sel_found = 1'b1;
            sel       = hi_pick;
        end else if (lo_found) begin
            sel_found = 1'b1;
            sel       = lo_pick;
        end
    end

    // Steer ready back to the selected requester and mux its data and last.
    always_comb begin
        ready_o  = '0;
        sel_data = '0;
        sel_last = 1'b0;
        for (int r = 0; r < N_REQ; r++) begin
            if (ID_W'(r) == sel) begin
                sel_data = data_i[r*DATA_W +: DATA_W];
                sel_last = last_i[r];
                if (!rst && load_en && sel_found) begin
                    ready_o[r] = 1'b1;
                end
            end
        end
    end

    assign xfer     = |(ready_o & valid_i);
    assign next_ptr = (sel == ID_W'(N_REQ - 1)) ? '0 : sel + ID_W'(1);

    // Packet-lock FSM; the pointer moves only when a packet ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            busy_o <= 1'b0;
        end else if (xfer) begin
            case (state)
                IDLE: begin
                    if (!sel_last) begin
                        state  <= LOCKED;
                        owner  <= sel;
                        busy_o <= 1'b1;
                    end else begin
                        rr_ptr <= next_ptr;
                    end
                end
                LOCKED: begin
                    if (sel_last) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        rr_ptr <= next_ptr;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    // Output stage: capture a granted beat, empty on a consumed slot with no
    // new beat, and hold everything while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            last_o  <= 1'b0;
            src_o   <= '0;
        end else if (load_en) begin
            valid_o <= xfer;
            if (xfer) begin
                data_o <= sel_data;
                last_o <= sel_last;
                src_o  <= sel;
            end
        end
    end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed scoreboard bench for rr_stream_arbiter: stimulus pushes expected
// output beats, an independent monitor pops them as the DUT presents beats.
module tb_rr_stream_arbiter;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 32;
    localparam int ID_W   = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        valid_i;
    logic [N_REQ-1:0]        ready_o;
    logic [N_REQ*DATA_W-1:0] data_i;
    logic [N_REQ-1:0]        last_i;
    logic                    valid_o;
    logic                    ready_i;
    logic [DATA_W-1:0]       data_o;
    logic                    last_o;
    logic [ID_W-1:0]         src_o;
    logic                    busy_o;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [ID_W-1:0]   src;
        logic              busy;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    rr_stream_arbiter #(
        .N_REQ (N_REQ),
        .DATA_W(DATA_W),
        .ID_W  (ID_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i (data_i),
        .last_i (last_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .data_o (data_o),
        .last_o (last_o),
        .src_o  (src_o),
        .busy_o (busy_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input logic [ID_W-1:0] src, input logic [DATA_W-1:0] data,
                                input logic last, input logic busy);
        beat_t b;
        b.data = data;
        b.last = last;
        b.src  = src;
        b.busy = busy;
        exp_q.push_back(b);
    endtask

    task automatic setData(input int r, input logic [DATA_W-1:0] value);
        data_i[r*DATA_W +: DATA_W] = value;
    endtask

    // Drive valid/last, then advance to just after the next rising edge.
    task automatic applyStimulus(input logic [N_REQ-1:0] v, input logic [N_REQ-1:0] l);
        valid_i = v;
        last_i  = l;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every beat consumed downstream must match the queue head.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (valid_o === 1'b1 && ready_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got src %0d data %0h, expected no beat",
                             src_o, data_o);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("beat_src",  64'(src_o),  64'(e.src));
                    checkOutput("beat_data", 64'(data_o), 64'(e.data));
                    checkOutput("beat_last", 64'(last_o), 64'(e.last));
                    checkOutput("beat_busy", 64'(busy_o), 64'(e.busy));
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        valid_i = '0;
        last_i  = '0;
        data_i  = '0;
        ready_i = 1'b1;

        // Reset: ready stays low even with every requester valid.
        @(posedge clk);
        #1;
        valid_i = 4'b1111;
        last_i  = 4'b1111;
        @(negedge clk);
        checkOutput("reset_ready_o", 64'(ready_o), 64'(0));
        @(posedge clk);
        #1;
        rst     = 1'b0;
        valid_i = '0;
        @(negedge clk);
        checkOutput("reset_valid_o", 64'(valid_o), 64'(0));
        checkOutput("reset_busy_o",  64'(busy_o),  64'(0));
        checkOutput("reset_data_o",  64'(data_o),  64'(0));
        checkOutput("reset_src_o",   64'(src_o),   64'(0));
        checkOutput("reset_last_o",  64'(last_o),  64'(0));
        @(posedge clk);
        #1;

        // Single-beat packets from all four: strict rotation 0,1,2,3,0.
        $display("[TB] rotation of single-beat packets");
        for (int r = 0; r < N_REQ; r++) setData(r, 32'hA000_0000 + 32'(r));
        pushExpected(0, 32'hA000_0000, 1'b1, 1'b0);
        pushExpected(1, 32'hA000_0001, 1'b1, 1'b0);
        pushExpected(2, 32'hA000_0002, 1'b1, 1'b0);
        pushExpected(3, 32'hA000_0003, 1'b1, 1'b0);
        pushExpected(0, 32'hA000_0000, 1'b1, 1'b0);
        applyStimulus(4'b1111, 4'b1111);
        @(negedge clk);
        checkOutput("first_latency_valid", 64'(valid_o), 64'(1));
        @(posedge clk);
        #1;
        repeat (3) applyStimulus(4'b1111, 4'b1111);
        applyStimulus(4'b0000, 4'b1111);
        applyStimulus(4'b0000, 4'b1111);

        // Pointer now at 1: req1 alone moves it to 2, then req2 wins a
        // 3-beat packet against reqs 0/1; afterwards req0 then req1.
        $display("[TB] locked 3-beat packet from req 2");
        setData(0, 32'h0000_0A00);
        setData(1, 32'h1111_0001);
        pushExpected(1, 32'h1111_0001, 1'b1, 1'b0);
        pushExpected(2, 32'hD000_0000, 1'b0, 1'b1);
        pushExpected(2, 32'hD000_0001, 1'b0, 1'b1);
        pushExpected(2, 32'hD000_0002, 1'b1, 1'b0);
        pushExpected(0, 32'h0000_0A00, 1'b1, 1'b0);
        pushExpected(1, 32'h1111_0001, 1'b1, 1'b0);
        applyStimulus(4'b0010, 4'b1111);
        setData(2, 32'hD000_0000);
        applyStimulus(4'b0111, 4'b1011);
        setData(2, 32'hD000_0001);
        applyStimulus(4'b0111, 4'b1011);
        setData(2, 32'hD000_0002);
        applyStimulus(4'b0111, 4'b1111);
        applyStimulus(4'b0011, 4'b1111);
        applyStimulus(4'b0010, 4'b1111);
        applyStimulus(4'b0000, 4'b1111);
        applyStimulus(4'b0000, 4'b1111);

        // Downstream stall: output frozen, no ready, nothing lost.
        $display("[TB] downstream stall");
        setData(3, 32'hC300_0003);
        setData(0, 32'hC000_0000);
        pushExpected(3, 32'hC300_0003, 1'b1, 1'b0);
        pushExpected(0, 32'hC000_0000, 1'b1, 1'b0);
        applyStimulus(4'b1000, 4'b1111);
        ready_i = 1'b0;
        valid_i = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_valid_o", 64'(valid_o), 64'(1));
            checkOutput("stall_src_o",   64'(src_o),   64'(3));
            checkOutput("stall_data_o",  64'(data_o),  64'(32'hC300_0003));
            checkOutput("stall_ready_o", 64'(ready_o), 64'(0));
            @(posedge clk);
            #1;
        end
        ready_i = 1'b1;
        applyStimulus(4'b0001, 4'b1111);
        applyStimulus(4'b0000, 4'b1111);
        applyStimulus(4'b0000, 4'b1111);

        // Owner 1 bubbles for 3 cycles while req0 waits; packet stays whole.
        $display("[TB] owner bubble while locked");
        setData(1, 32'hB100_0000);
        setData(0, 32'hB000_0000);
        pushExpected(1, 32'hB100_0000, 1'b0, 1'b1);
        pushExpected(1, 32'hB100_0001, 1'b0, 1'b1);
        pushExpected(1, 32'hB100_0002, 1'b1, 1'b0);
        pushExpected(0, 32'hB000_0000, 1'b1, 1'b0);
        applyStimulus(4'b0010, 4'b1101);
        valid_i = 4'b0001;
        last_i  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bubble_busy_o",  64'(busy_o),  64'(1));
            checkOutput("bubble_ready_o", 64'(ready_o), 64'(4'b0010));
            @(posedge clk);
            #1;
        end
        setData(1, 32'hB100_0001);
        applyStimulus(4'b0011, 4'b1101);
        setData(1, 32'hB100_0002);
        applyStimulus(4'b0011, 4'b1111);
        applyStimulus(4'b0001, 4'b1111);
        applyStimulus(4'b0000, 4'b1111);
        applyStimulus(4'b0000, 4'b1111);

        // Reset mid-packet from req3; afterwards req0 beats req3.
        $display("[TB] reset during locked packet");
        setData(3, 32'hE300_0000);
        pushExpected(3, 32'hE300_0000, 1'b0, 1'b1);
        applyStimulus(4'b1000, 4'b0111);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_ready_o", 64'(ready_o), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        setData(0, 32'hE000_0000);
        setData(3, 32'hE300_0001);
        valid_i = 4'b1001;
        last_i  = 4'b1111;
        @(negedge clk);
        checkOutput("postrst_valid_o", 64'(valid_o), 64'(0));
        checkOutput("postrst_busy_o",  64'(busy_o),  64'(0));
        pushExpected(0, 32'hE000_0000, 1'b1, 1'b0);
        pushExpected(3, 32'hE300_0001, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(4'b1000, 4'b1111);
        applyStimulus(4'b0000, 4'b1111);
        repeat (4) applyStimulus(4'b0000, 4'b1111);

        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
